// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, MIPS opcode/funct
// constants and the ALU operation codes driven on ALUConf.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RST, S_IF, S_ID, S_EXR, S_EXI, S_MADR, S_MRD,
    S_MWB, S_MWR, S_BR, S_JMP, S_JR, S_WBA
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_SLL = 5'd6;
  localparam logic [4:0] ALU_SRL = 5'd7;
  localparam logic [4:0] ALU_SRA = 5'd8;
  localparam logic [4:0] ALU_SLT = 5'd9;
  localparam logic [4:0] ALU_LUI = 5'd10;

  // Shifts take the shamt field on ALU port A instead of rs.
  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

  // R-type functs that execute through EXR (jr/jalr are routed to JR).
  function automatic logic is_r_alu(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_i_alu(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode/funct to ALU operation and signed-compare decode.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [4:0] alu_conf,
  output logic       sign
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    alu_conf = ALU_ADD;
    sign     = 1'b1;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_conf = ALU_SUB;
        FN_SUBU: begin alu_conf = ALU_SUB; sign = 1'b0; end
        FN_ADDU: sign = 1'b0;
        FN_AND:  alu_conf = ALU_AND;
        FN_OR:   alu_conf = ALU_OR;
        FN_XOR:  alu_conf = ALU_XOR;
        FN_NOR:  alu_conf = ALU_NOR;
        FN_SLL:  alu_conf = ALU_SLL;
        FN_SRL:  alu_conf = ALU_SRL;
        FN_SRA:  alu_conf = ALU_SRA;
        FN_SLT:  alu_conf = ALU_SLT;
        FN_SLTU: begin alu_conf = ALU_SLT; sign = 1'b0; end
        default: ;
      endcase
    end else begin
      case (opcode)
        OP_ADDIU: sign = 1'b0;
        OP_ANDI:  alu_conf = ALU_AND;
        OP_SLTI:  alu_conf = ALU_SLT;
        OP_SLTIU: begin alu_conf = ALU_SLT; sign = 1'b0; end
        OP_LUI:   alu_conf = ALU_LUI;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: state register plus Moore output decode from the
// current state and the instruction-register OpCode/Funct fields.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [4:0] ALUConf,
  output logic       Sign,
  output logic       Illegal
);

  state_e     state;
  logic [4:0] dec_conf;
  logic       dec_sign;

  mc_alu_decode u_alu_decode (
    .opcode   (OpCode),
    .funct    (Funct),
    .alu_conf (dec_conf),
    .sign     (dec_sign)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST: state <= S_IF;
        S_IF:  state <= S_ID;
        S_ID: begin
          if (OpCode == OP_RTYPE) begin
            if (Funct == FN_JR || Funct == FN_JALR) state <= S_JR;
            else if (is_r_alu(Funct))               state <= S_EXR;
            else                                    state <= S_IF;
          end else if (OpCode == OP_LW || OpCode == OP_SW) state <= S_MADR;
          else if (OpCode == OP_BEQ)                       state <= S_BR;
          else if (OpCode == OP_J || OpCode == OP_JAL)     state <= S_JMP;
          else if (is_i_alu(OpCode))                       state <= S_EXI;
          else                                             state <= S_IF;
        end
        S_EXR, S_EXI: state <= S_WBA;
        S_MADR:       state <= (OpCode == OP_LW) ? S_MRD : S_MWR;
        S_MRD:        state <= S_MWB;
        default:      state <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; ExtOp = 1'b0;
    LuiOp = 1'b0; RegDst = 2'b00; MemtoReg = 2'b00; ALUSrcA = 2'b00;
    ALUSrcB = 2'b00; PCSource = 2'b00; ALUConf = ALU_ADD; Sign = 1'b0;
    Illegal = 1'b0;
    case (state)
      S_IF: begin
        MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'b01;
      end
      S_ID: begin
        ALUSrcB = 2'b11; ExtOp = 1'b1;
        if (OpCode == OP_RTYPE)
          Illegal = !(is_r_alu(Funct) || Funct == FN_JR || Funct == FN_JALR);
        else
          Illegal = !(OpCode == OP_LW || OpCode == OP_SW || OpCode == OP_BEQ ||
                      OpCode == OP_J || OpCode == OP_JAL || is_i_alu(OpCode));
      end
      S_EXR: begin
        ALUSrcA = is_shift(Funct) ? 2'b10 : 2'b01;
        ALUConf = dec_conf; Sign = dec_sign;
      end
      S_EXI: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10;
        ExtOp = (OpCode != OP_ANDI); LuiOp = (OpCode == OP_LUI);
        ALUConf = dec_conf; Sign = dec_sign;
      end
      S_WBA: begin
        RegWrite = 1'b1; RegDst = (OpCode == OP_RTYPE) ? 2'b01 : 2'b00;
      end
      S_MADR: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ExtOp = 1'b1; Sign = dec_sign;
      end
      S_MRD: begin MemRead = 1'b1; IorD = 1'b1; end
      S_MWB: begin RegWrite = 1'b1; MemtoReg = 2'b01; end
      S_MWR: begin MemWrite = 1'b1; IorD = 1'b1; end
      S_BR: begin
        ALUSrcA = 2'b01; ALUConf = ALU_SUB; Sign = dec_sign;
        PCWriteCond = 1'b1; PCSource = 2'b01;
      end
      S_JMP: begin
        PCWrite = 1'b1; PCSource = 2'b10;
        if (OpCode == OP_JAL) begin RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10; end
      end
      S_JR: begin
        PCWrite = 1'b1; PCSource = 2'b11;
        if (Funct == FN_JALR) begin RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-instruction vector table plus reset sequences.
module tb_mc_controller;

  logic       clk, reset;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [4:0] ALUConf;
  logic       Sign, Illegal;

  mc_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .LuiOp(LuiOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUConf(ALUConf), .Sign(Sign),
    .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable bits in order {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ExtOp,LuiOp}.
  localparam logic [8:0] EN_PCW  = 9'h100;
  localparam logic [8:0] EN_PCWC = 9'h080;
  localparam logic [8:0] EN_IORD = 9'h040;
  localparam logic [8:0] EN_MRD  = 9'h020;
  localparam logic [8:0] EN_MWR  = 9'h010;
  localparam logic [8:0] EN_IRW  = 9'h008;
  localparam logic [8:0] EN_RW   = 9'h004;
  localparam logic [8:0] EN_EXT  = 9'h002;
  localparam logic [8:0] EN_LUI  = 9'h001;

  function automatic logic [25:0] pk(input logic [8:0] en, input logic [1:0] rdst, m2r,
                                     srca, srcb, pcs, input logic [4:0] conf,
                                     input logic sgn, ill);
    return {en, rdst, m2r, srca, srcb, pcs, conf, sgn, ill};
  endfunction

  logic [25:0] cur;
  assign cur = pk({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp},
                  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUConf, Sign, Illegal);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    int          cycles;
    int          cyc;
    logic [25:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [25:0] snap[16];
  int          n;

  function automatic logic [25:0] w_if();
    return pk(EN_MRD | EN_IRW | EN_PCW, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [25:0] w_id(input logic ill);
    return pk(EN_EXT, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 5'd0, 1'b0, ill);
  endfunction

  // Runs one instruction starting from an IF cycle; records outputs until the next IF.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    OpCode = op;
    Funct  = fn;
    snap[0] = cur;
    n = 1;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("mem excl", {31'b0, MemRead & MemWrite}, 32'd0);
      check("illegal vs writes",
            {31'b0, Illegal & (PCWrite | PCWriteCond | MemWrite | RegWrite | IRWrite)}, 32'd0);
      if (IRWrite) break;
      snap[k] = cur;
      n = k + 1;
    end
  endtask

  initial begin
    reset  = 1'b0;
    OpCode = 6'h00;
    Funct  = 6'h00;

    // Reset: outputs zero while held, still zero in RST, IF one edge later.
    #12;
    check("reset held", cur, 26'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst state", cur, 26'd0);
    @(negedge clk);
    check("if after reset", cur, w_if());

    vecs.push_back('{"add id",    6'h00, 6'h20, 4, 1, w_id(1'b0)});
    vecs.push_back('{"add exr",   6'h00, 6'h20, 4, 2, pk(0, 0, 0, 2'b01, 0, 0, 5'd0, 1, 0)});
    vecs.push_back('{"add wba",   6'h00, 6'h20, 4, 3, pk(EN_RW, 2'b01, 0, 0, 0, 0, 5'd0, 0, 0)});
    vecs.push_back('{"sub exr",   6'h00, 6'h22, 4, 2, pk(0, 0, 0, 2'b01, 0, 0, 5'd1, 1, 0)});
    vecs.push_back('{"subu exr",  6'h00, 6'h23, 4, 2, pk(0, 0, 0, 2'b01, 0, 0, 5'd1, 0, 0)});
    vecs.push_back('{"sra exr",   6'h00, 6'h03, 4, 2, pk(0, 0, 0, 2'b10, 0, 0, 5'd8, 1, 0)});
    vecs.push_back('{"sltu exr",  6'h00, 6'h2B, 4, 2, pk(0, 0, 0, 2'b01, 0, 0, 5'd9, 0, 0)});
    vecs.push_back('{"nor exr",   6'h00, 6'h27, 4, 2, pk(0, 0, 0, 2'b01, 0, 0, 5'd5, 1, 0)});
    vecs.push_back('{"lw madr",   6'h23, 6'h00, 5, 2, pk(EN_EXT, 0, 0, 2'b01, 2'b10, 0, 5'd0, 1, 0)});
    vecs.push_back('{"lw mrd",    6'h23, 6'h00, 5, 3, pk(EN_MRD | EN_IORD, 0, 0, 0, 0, 0, 5'd0, 0, 0)});
    vecs.push_back('{"lw mwb",    6'h23, 6'h00, 5, 4, pk(EN_RW, 0, 2'b01, 0, 0, 0, 5'd0, 0, 0)});
    vecs.push_back('{"sw mwr",    6'h2B, 6'h00, 4, 3, pk(EN_MWR | EN_IORD, 0, 0, 0, 0, 0, 5'd0, 0, 0)});
    vecs.push_back('{"sltiu exi", 6'h0B, 6'h00, 4, 2, pk(EN_EXT, 0, 0, 2'b01, 2'b10, 0, 5'd9, 0, 0)});
    vecs.push_back('{"andi exi",  6'h0C, 6'h00, 4, 2, pk(0, 0, 0, 2'b01, 2'b10, 0, 5'd2, 1, 0)});
    vecs.push_back('{"lui exi",   6'h0F, 6'h00, 4, 2, pk(EN_EXT | EN_LUI, 0, 0, 2'b01, 2'b10, 0, 5'd10, 1, 0)});
    vecs.push_back('{"addi wba",  6'h08, 6'h00, 4, 3, pk(EN_RW, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0)});
    vecs.push_back('{"beq br",    6'h04, 6'h00, 3, 2, pk(EN_PCWC, 0, 0, 2'b01, 0, 2'b01, 5'd1, 1, 0)});
    vecs.push_back('{"j jmp",     6'h02, 6'h00, 3, 2, pk(EN_PCW, 0, 0, 0, 0, 2'b10, 5'd0, 0, 0)});
    vecs.push_back('{"jal jmp",   6'h03, 6'h00, 3, 2, pk(EN_PCW | EN_RW, 2'b10, 2'b10, 0, 0, 2'b10, 5'd0, 0, 0)});
    vecs.push_back('{"jr jr",     6'h00, 6'h08, 3, 2, pk(EN_PCW, 0, 0, 0, 0, 2'b11, 5'd0, 0, 0)});
    vecs.push_back('{"jalr jr",   6'h00, 6'h09, 3, 2, pk(EN_PCW | EN_RW, 2'b10, 2'b10, 0, 0, 2'b11, 5'd0, 0, 0)});
    vecs.push_back('{"op3f id",   6'h3F, 6'h00, 2, 1, w_id(1'b1)});
    vecs.push_back('{"badfn id",  6'h00, 6'h3F, 2, 1, w_id(1'b1)});
    vecs.push_back('{"ori id",    6'h0D, 6'h00, 2, 1, w_id(1'b1)});

    foreach (vecs[i]) begin
      check({vecs[i].name, " if"}, cur, w_if());
      run_instr(vecs[i].op, vecs[i].fn);
      check({vecs[i].name, " cycles"}, 32'(n), 32'(vecs[i].cycles));
      check(vecs[i].name, snap[vecs[i].cyc], vecs[i].exp);
    end

    // Reset pulsed during MRD: outputs clear without a clock edge, then RST, then IF.
    check("pre-lw if", cur, w_if());
    OpCode = 6'h23;
    Funct  = 6'h00;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("lw reach mrd", cur, pk(EN_MRD | EN_IORD, 0, 0, 0, 0, 0, 5'd0, 0, 0));
    #2 reset = 1'b0;
    #1 check("async reset", cur, 26'd0);
    @(negedge clk);
    check("reset held mid", cur, 26'd0);
    reset = 1'b1;
    #1 check("rst after abort", cur, 26'd0);
    @(negedge clk);
    check("if after abort", cur, w_if());

    // Normal operation resumes after the abort.
    run_instr(6'h00, 6'h24);
    check("and after abort cycles", 32'(n), 32'd4);
    check("and after abort exr", snap[2], pk(0, 0, 0, 2'b01, 0, 0, 5'd2, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
